// File: rtl/rx_ds_char_pkg.sv
// Shared definitions for the data/strobe character link: FSM encodings,
// payload lengths and control codes common to the transmitter and receiver.
package rx_ds_char_pkg;

  typedef enum logic [1:0] {
    ST_PARITY = 2'd0,
    ST_FLAG   = 2'd1,
    ST_DATA   = 2'd2,
    ST_ERROR  = 2'd3
  } rx_state_e;

  localparam int DATA_LEN = 8;
  localparam int CTRL_LEN = 2;
  localparam int CNT_W    = 4;

  localparam logic [1:0] LCHAR_FCT = 2'b00;
  localparam logic [1:0] LCHAR_EOP = 2'b01;
  localparam logic [1:0] LCHAR_EEP = 2'b10;
  localparam logic [1:0] LCHAR_ESC = 2'b11;

  // The flag selects how many payload strobes follow.
  function automatic logic [CNT_W-1:0] payload_len(input logic lflag);
    return lflag ? CNT_W'(CTRL_LEN) : CNT_W'(DATA_LEN);
  endfunction

endpackage

// File: rtl/rx_ds_char.sv
// Character receiver for the data/strobe link: frames parity/flag/payload,
// checks odd parity across characters and hands characters out via valid/ready.
//
// state     | meaning
// ----------+--------------------------------------------------------------
// ST_PARITY | next strobe is the parity bit of a new character
// ST_FLAG   | next strobe is the data/control flag; parity is checked here
// ST_DATA   | collecting payload bits LSB-first, cnt bits remain
// ST_ERROR  | fatal parity or line fault seen; strobes dropped until reset
module rx_ds_char
  import rx_ds_char_pkg::*;
(
  input  logic       RxClk,
  input  logic       RxReset,
  input  logic       rx_stb_i,
  input  logic       Rx1,
  input  logic       Rx0,
  output logic       valid_o,
  input  logic       ready_i,
  output logic [7:0] dat_o,
  output logic       lchar_o,
  output logic       parity_err_o,
  output logic       line_err_o,
  output logic       overrun_o
);

  rx_state_e        state;
  logic             acc;
  logic             pbit;
  logic             lflag;
  logic [CNT_W-1:0] cnt;
  logic [7:0]       shreg;

  logic             line_bad;
  logic [7:0]       sh_nxt;
  logic             complete;
  logic [7:0]       char_dat;

  always_comb begin
    line_bad = rx_stb_i && (Rx1 == Rx0);
    sh_nxt   = {Rx1, shreg[7:1]};
    complete = rx_stb_i && !line_bad && (state == ST_DATA) && (cnt == CNT_W'(1));
    // Control payload lands in the top two bits of the shifter; right-align it.
    char_dat = lflag ? {6'b0, sh_nxt[7:6]} : sh_nxt;
  end

  always_ff @(posedge RxClk or negedge RxReset) begin
    if (!RxReset) begin
      state        <= ST_PARITY;
      acc          <= 1'b0;
      pbit         <= 1'b0;
      lflag        <= 1'b0;
      cnt          <= '0;
      shreg        <= '0;
      parity_err_o <= 1'b0;
      line_err_o   <= 1'b0;
    end else if (rx_stb_i && state != ST_ERROR) begin
      if (line_bad) begin
        line_err_o <= 1'b1;
        state      <= ST_ERROR;
      end else begin
        case (state)
          ST_PARITY: begin
            pbit  <= Rx1;
            state <= ST_FLAG;
          end
          ST_FLAG: begin
            // Parity covers the previous payload plus this parity and flag bit.
            if (acc ^ pbit ^ Rx1) begin
              lflag <= Rx1;
              acc   <= 1'b0;
              cnt   <= payload_len(Rx1);
              shreg <= '0;
              state <= ST_DATA;
            end else begin
              parity_err_o <= 1'b1;
              state        <= ST_ERROR;
            end
          end
          ST_DATA: begin
            shreg <= sh_nxt;
            acc   <= acc ^ Rx1;
            cnt   <= cnt - CNT_W'(1);
            if (cnt == CNT_W'(1)) state <= ST_PARITY;
          end
          ST_ERROR: state <= ST_ERROR;
        endcase
      end
    end
  end

  always_ff @(posedge RxClk or negedge RxReset) begin
    if (!RxReset) begin
      valid_o   <= 1'b0;
      dat_o     <= '0;
      lchar_o   <= 1'b0;
      overrun_o <= 1'b0;
    end else if (complete) begin
      if (!valid_o || ready_i) begin
        valid_o <= 1'b1;
        dat_o   <= char_dat;
        lchar_o <= lflag;
      end else begin
        overrun_o <= 1'b1;
      end
    end else if (valid_o && ready_i) begin
      valid_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_rx_ds_char.sv
// Directed bench for rx_ds_char: drives dual-rail strobes and checks framing,
// parity, line errors, overrun and asynchronous reset against hand values.
module tb_rx_ds_char;
  import rx_ds_char_pkg::*;

  logic       RxClk = 1'b0;
  logic       RxReset = 1'b0;
  logic       rx_stb_i = 1'b0;
  logic       Rx1 = 1'b0;
  logic       Rx0 = 1'b1;
  logic       ready_i = 1'b0;
  logic       valid_o;
  logic [7:0] dat_o;
  logic       lchar_o;
  logic       parity_err_o;
  logic       line_err_o;
  logic       overrun_o;

  int n_tests = 0;
  int n_fail  = 0;
  int vcnt    = 0;
  int vsnap   = 0;
  logic m_acc = 1'b0;

  rx_ds_char dut (
    .RxClk        (RxClk),
    .RxReset      (RxReset),
    .rx_stb_i     (rx_stb_i),
    .Rx1          (Rx1),
    .Rx0          (Rx0),
    .valid_o      (valid_o),
    .ready_i      (ready_i),
    .dat_o        (dat_o),
    .lchar_o      (lchar_o),
    .parity_err_o (parity_err_o),
    .line_err_o   (line_err_o),
    .overrun_o    (overrun_o)
  );

  always #5 RxClk = ~RxClk;

  always @(negedge RxClk) if (valid_o) vcnt++;

  task automatic check_val(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%02h, expected 0x%02h", tag, got, exp);
    end
  endtask

  task automatic strobe_raw(input logic r1, input logic r0);
    rx_stb_i = 1'b1;
    Rx1 = r1;
    Rx0 = r0;
    @(posedge RxClk);
    #1;
    rx_stb_i = 1'b0;
  endtask

  task automatic strobe(input logic b);
    strobe_raw(b, ~b);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge RxClk);
    #1;
  endtask

  task automatic do_reset();
    RxReset = 1'b0;
    rx_stb_i = 1'b0;
    idle(2);
    RxReset = 1'b1;
    m_acc = 1'b0;
  endtask

  // Sends one clean character; the parity bit comes from the bench's own
  // record of the previous payload parity. Optionally raises ready_i just
  // before the last payload strobe.
  task automatic send_char(input logic is_ctrl, input logic [7:0] payload, input logic rdy_last);
    int   n;
    logic par;
    n = is_ctrl ? 2 : 8;
    strobe(1'b1 ^ m_acc ^ is_ctrl);
    strobe(is_ctrl);
    par = 1'b0;
    for (int i = 0; i < n; i++) begin
      if (rdy_last && i == n - 1) ready_i = 1'b1;
      strobe(payload[i]);
      par ^= payload[i];
    end
    m_acc = par;
  endtask

  task automatic check_reset_outputs(input string tag);
    check_val({tag, "_valid"},  {7'b0, valid_o},      8'h00);
    check_val({tag, "_dat"},    dat_o,                8'h00);
    check_val({tag, "_lchar"},  {7'b0, lchar_o},      8'h00);
    check_val({tag, "_perr"},   {7'b0, parity_err_o}, 8'h00);
    check_val({tag, "_lerr"},   {7'b0, line_err_o},   8'h00);
    check_val({tag, "_ovr"},    {7'b0, overrun_o},    8'h00);
  endtask

  initial begin
    do_reset();
    check_reset_outputs("rst");

    // Data 0xA5 then control EOP back-to-back with ready held high.
    ready_i = 1'b1;
    vsnap = vcnt;
    send_char(1'b0, 8'hA5, 1'b0);
    check_val("a5_valid", {7'b0, valid_o}, 8'h01);
    check_val("a5_dat",   dat_o,           8'hA5);
    check_val("a5_lchar", {7'b0, lchar_o}, 8'h00);
    check_val("a5_perr",  {7'b0, parity_err_o}, 8'h00);
    check_val("a5_lerr",  {7'b0, line_err_o},   8'h00);
    check_val("a5_ovr",   {7'b0, overrun_o},    8'h00);
    send_char(1'b1, {6'b0, LCHAR_EOP}, 1'b0);
    check_val("eop_valid", {7'b0, valid_o}, 8'h01);
    check_val("eop_dat",   dat_o,           8'h01);
    check_val("eop_lchar", {7'b0, lchar_o}, 8'h01);
    idle(3);
    check_val("b2b_valid_cycles", 8'(vcnt - vsnap), 8'd2);
    check_val("b2b_valid_low",    {7'b0, valid_o},  8'h00);

    // Parity fault: 0xA5 then a data character with parity inverted.
    do_reset();
    ready_i = 1'b1;
    send_char(1'b0, 8'hA5, 1'b0);
    idle(2);
    vsnap = vcnt;
    strobe(1'b0);
    strobe(1'b0);
    check_val("perr_set",  {7'b0, parity_err_o}, 8'h01);
    check_val("perr_lerr", {7'b0, line_err_o},   8'h00);
    for (int i = 0; i < 8; i++) strobe(i[0]);
    m_acc = 1'b0;
    send_char(1'b0, 8'h5A, 1'b0);
    idle(2);
    check_val("perr_no_valid", 8'(vcnt - vsnap), 8'd0);
    check_val("perr_sticky",   {7'b0, parity_err_o}, 8'h01);

    // Line fault mid-payload.
    do_reset();
    ready_i = 1'b1;
    vsnap = vcnt;
    strobe(1'b1);
    strobe(1'b0);
    strobe(1'b1);
    strobe(1'b0);
    strobe(1'b1);
    strobe_raw(1'b1, 1'b1);
    check_val("lerr_set",  {7'b0, line_err_o},   8'h01);
    check_val("lerr_perr", {7'b0, parity_err_o}, 8'h00);
    for (int i = 0; i < 5; i++) strobe(1'b0);
    idle(2);
    check_val("lerr_no_valid", 8'(vcnt - vsnap), 8'd0);

    // Overrun with ready held low, then ready rises as 0x44 completes.
    do_reset();
    ready_i = 1'b0;
    send_char(1'b0, 8'h11, 1'b0);
    check_val("ov_11_valid", {7'b0, valid_o}, 8'h01);
    check_val("ov_11_dat",   dat_o,           8'h11);
    check_val("ov_11_ovr",   {7'b0, overrun_o}, 8'h00);
    send_char(1'b0, 8'h22, 1'b0);
    check_val("ov_22_dat",  dat_o,              8'h11);
    check_val("ov_22_ovr",  {7'b0, overrun_o},  8'h01);
    send_char(1'b0, 8'h33, 1'b0);
    check_val("ov_33_dat",  dat_o,              8'h11);
    check_val("ov_33_perr", {7'b0, parity_err_o}, 8'h00);
    check_val("ov_33_lerr", {7'b0, line_err_o},   8'h00);
    send_char(1'b0, 8'h44, 1'b1);
    check_val("ov_44_valid", {7'b0, valid_o},   8'h01);
    check_val("ov_44_dat",   dat_o,             8'h44);
    check_val("ov_44_ovr",   {7'b0, overrun_o}, 8'h01);
    idle(1);
    check_val("ov_44_taken", {7'b0, valid_o},   8'h00);

    // Asynchronous reset after five payload strobes, then a clean 0x5A.
    ready_i = 1'b0;
    strobe(1'b1 ^ m_acc);
    strobe(1'b0);
    for (int i = 0; i < 5; i++) strobe(1'b1);
    RxReset = 1'b0;
    #1;
    check_reset_outputs("arst");
    idle(1);
    RxReset = 1'b1;
    m_acc = 1'b0;
    send_char(1'b0, 8'h5A, 1'b0);
    check_val("post_valid", {7'b0, valid_o}, 8'h01);
    check_val("post_dat",   dat_o,           8'h5A);
    check_val("post_lchar", {7'b0, lchar_o}, 8'h00);
    check_val("post_perr",  {7'b0, parity_err_o}, 8'h00);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
